// File: rtl/mem_data_port.sv
`timescale 1ns/1ps
// mem_data_port
//   Byte/half/word load-store port between the pipeline and a synchronous
//   32-bit RAM (read data valid one cycle after RAM_RE). Handles lane
//   selection and rotation for stores, and extraction with sign/zero extension
//   for loads. Optionally splits misaligned accesses into two RAM beats.
//
//   Build option: define MEM_SPLIT_MISALIGNED_EN to compile in misaligned
//   splitting (states LD2/LD2R/ST2 and BUSY). Without it, BUSY is tied low
//   and every misaligned access returns ERR.
//   Parameter MISALIGN_ERR_ONLY=1 makes misaligned accesses ERR even when
//   splitting is compiled in.
//
// Ports
//   CLK, RST_N          clock (rising edge), asynchronous active-low reset
//   MEM_RDEN2/MEM_WE2   one-cycle load / store request strobes
//   MEM_ADDR2           byte address
//   MEM_DIN2            store data (right-justified)
//   MEM_SIZE            00 byte, 01 half, 10 word, 11 reserved
//   MEM_UNSIGNED        load zero-extend
//   MEM_DOUT2           load result (held between returns)
//   BUSY                second beat of a split access in progress
//   ERR                 one-cycle access fault pulse, cycle after request
//   RAM_*               word-addressed synchronous RAM interface
module mem_data_port #(
  parameter int MISALIGN_ERR_ONLY = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        MEM_RDEN2,
  input  logic        MEM_WE2,
  input  logic [31:0] MEM_ADDR2,
  input  logic [31:0] MEM_DIN2,
  input  logic [1:0]  MEM_SIZE,
  input  logic        MEM_UNSIGNED,
  output logic [31:0] MEM_DOUT2,
  output logic        BUSY,
  output logic        ERR,
  output logic [29:0] RAM_ADDR,
  output logic [31:0] RAM_WDATA,
  output logic [3:0]  RAM_BE,
  output logic        RAM_WE,
  output logic        RAM_RE,
  input  logic [31:0] RAM_RDATA
);

`ifdef MEM_SPLIT_MISALIGNED_EN
  localparam logic SPLIT_BUILD = 1'b1;
  typedef enum logic [2:0] {IDLE, RESP, LD2, LD2R, ST2} state_t;
`else
  localparam logic SPLIT_BUILD = 1'b0;
  typedef enum logic [2:0] {IDLE, RESP} state_t;
`endif
  localparam logic SPLIT_OK = SPLIT_BUILD && (MISALIGN_ERR_ONLY == 0);

  state_t      state_reg;
  logic [1:0]  off_reg;
  logic [1:0]  size_reg;
  logic        uns_reg;
  logic [31:0] dout_reg;
  logic        err_reg;
`ifdef MEM_SPLIT_MISALIGNED_EN
  logic [29:0] addr2_reg;   // word address of the second beat
  logic [31:0] wdata_reg;   // rotated store data, reused for beat 2
  logic [3:0]  be2_reg;     // overflowed lanes for beat 2
  logic [31:0] lo_reg;      // first-beat read data of a split load
`endif

  // Shift the {high word, low word} pair right by the byte offset, then
  // extend according to size. Aligned loads pass zero as the high word.
  function automatic logic [31:0] extract(input logic [63:0] pair,
                                          input logic [1:0]  off_b,
                                          input logic [1:0]  size_b,
                                          input logic        uns_b);
    logic [31:0] sh_d;
    sh_d = 32'(pair >> {off_b, 3'b000});
    case (size_b)
      2'b00:   extract = {{24{~uns_b & sh_d[7]}}, sh_d[7:0]};
      2'b01:   extract = {{16{~uns_b & sh_d[15]}}, sh_d[15:0]};
      default: extract = sh_d;
    endcase
  endfunction

  logic [1:0]  off;
  logic [4:0]  sh;
  logic [2:0]  nbytes;
  logic [3:0]  be_base;
  logic [3:0]  be1;
  logic        misaligned;
  logic        accept_ok;
  logic        req;
  logic        bad;
  logic        go;
  logic [31:0] wdata_rot;
  logic [31:0] dout_c;

  assign off = MEM_ADDR2[1:0];
  assign sh  = {off, 3'b000};

  always_comb begin
    nbytes  = 3'd0;
    be_base = 4'b0000;
    case (MEM_SIZE)
      2'b00:   begin nbytes = 3'd1; be_base = 4'b0001; end
      2'b01:   begin nbytes = 3'd2; be_base = 4'b0011; end
      2'b10:   begin nbytes = 3'd4; be_base = 4'b1111; end
      default: begin nbytes = 3'd0; be_base = 4'b0000; end
    endcase
  end

  assign misaligned = ({1'b0, off} + nbytes) > 3'd4;
  assign accept_ok  = (state_reg == IDLE) || (state_reg == RESP);
  assign req        = accept_ok && (MEM_RDEN2 || MEM_WE2);
  assign bad        = (MEM_SIZE == 2'b11) || (MEM_RDEN2 && MEM_WE2) ||
                      (misaligned && !SPLIT_OK);
  assign go         = req && !bad;
  // Lanes that fit in the first word; anything shifted past lane 3 is dropped
  assign be1        = be_base << off;
  // Rotation (not shift) so the bytes that overflow land in the low lanes,
  // ready for the second beat of a split store
  assign wdata_rot  = (MEM_DIN2 << sh) | (MEM_DIN2 >> (6'd32 - {1'b0, sh}));

`ifdef MEM_SPLIT_MISALIGNED_EN
  logic [3:0] be2;
  assign be2 = be_base >> (3'd4 - {1'b0, off});
`endif

  // RAM strobes are combinational from the request so the read is issued in
  // the request cycle; gated by RST_N so nothing strobes while in reset.
  always_comb begin
    RAM_ADDR  = MEM_ADDR2[31:2];
    RAM_WDATA = wdata_rot;
    RAM_BE    = 4'b0000;
    RAM_WE    = 1'b0;
    RAM_RE    = 1'b0;
    if (RST_N) begin
      case (state_reg)
`ifdef MEM_SPLIT_MISALIGNED_EN
        LD2: begin
          RAM_ADDR = addr2_reg;
          RAM_RE   = 1'b1;
        end
        ST2: begin
          RAM_ADDR  = addr2_reg;
          RAM_WDATA = wdata_reg;
          RAM_BE    = be2_reg;
          RAM_WE    = 1'b1;
        end
`endif
        default: begin
          if (go) begin
            RAM_RE = MEM_RDEN2;
            RAM_WE = MEM_WE2;
            RAM_BE = MEM_WE2 ? be1 : 4'b0000;
          end
        end
      endcase
    end
  end

  // Load data is returned straight from RAM_RDATA in return cycles and held
  // in dout_reg otherwise.
  always_comb begin
    dout_c = dout_reg;
    case (state_reg)
      RESP: dout_c = extract({32'h0, RAM_RDATA}, off_reg, size_reg, uns_reg);
`ifdef MEM_SPLIT_MISALIGNED_EN
      LD2R: dout_c = extract({RAM_RDATA, lo_reg}, off_reg, size_reg, uns_reg);
`endif
      default: dout_c = dout_reg;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= IDLE;
      off_reg   <= 2'd0;
      size_reg  <= 2'd0;
      uns_reg   <= 1'b0;
      dout_reg  <= 32'h0;
      err_reg   <= 1'b0;
`ifdef MEM_SPLIT_MISALIGNED_EN
      addr2_reg <= 30'd0;
      wdata_reg <= 32'h0;
      be2_reg   <= 4'b0000;
      lo_reg    <= 32'h0;
`endif
    end else begin
      err_reg  <= req && bad;
      dout_reg <= dout_c;
      case (state_reg)
`ifdef MEM_SPLIT_MISALIGNED_EN
        LD2: begin
          lo_reg    <= RAM_RDATA;
          state_reg <= LD2R;
        end
        LD2R, ST2: state_reg <= IDLE;
`endif
        default: begin
          if (go) begin
            off_reg  <= off;
            size_reg <= MEM_SIZE;
            uns_reg  <= MEM_UNSIGNED;
`ifdef MEM_SPLIT_MISALIGNED_EN
            addr2_reg <= MEM_ADDR2[31:2] + 30'd1;   // wraps at top of memory
            wdata_reg <= wdata_rot;
            be2_reg   <= be2;
`endif
          end
          if (go && MEM_RDEN2) state_reg <= RESP;
          else                 state_reg <= IDLE;
`ifdef MEM_SPLIT_MISALIGNED_EN
          if (go && misaligned) state_reg <= MEM_RDEN2 ? LD2 : ST2;
`endif
        end
      endcase
    end
  end

  assign ERR = err_reg;
`ifdef MEM_SPLIT_MISALIGNED_EN
  assign BUSY = (state_reg == LD2) || (state_reg == LD2R) || (state_reg == ST2);
`else
  assign BUSY = 1'b0;
`endif
  assign MEM_DOUT2 = dout_c;

endmodule

// File: tb/tb_mem_data_port.sv
`timescale 1ns/1ps
module tb_mem_data_port;

`ifdef MEM_SPLIT_MISALIGNED_EN
  localparam bit SPLIT_C = 1'b1;
`else
  localparam bit SPLIT_C = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        MEM_RDEN2 = 1'b0;
  logic        MEM_WE2 = 1'b0;
  logic [31:0] MEM_ADDR2 = 32'h0;
  logic [31:0] MEM_DIN2 = 32'h0;
  logic [1:0]  MEM_SIZE = 2'd0;
  logic        MEM_UNSIGNED = 1'b0;
  logic [31:0] MEM_DOUT2;
  logic        BUSY;
  logic        ERR;
  logic [29:0] RAM_ADDR;
  logic [31:0] RAM_WDATA;
  logic [3:0]  RAM_BE;
  logic        RAM_WE;
  logic        RAM_RE;
  logic [31:0] RAM_RDATA;

  always #5 CLK = ~CLK;

  mem_data_port #(.MISALIGN_ERR_ONLY(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .MEM_RDEN2(MEM_RDEN2), .MEM_WE2(MEM_WE2),
    .MEM_ADDR2(MEM_ADDR2), .MEM_DIN2(MEM_DIN2), .MEM_SIZE(MEM_SIZE),
    .MEM_UNSIGNED(MEM_UNSIGNED), .MEM_DOUT2(MEM_DOUT2), .BUSY(BUSY), .ERR(ERR),
    .RAM_ADDR(RAM_ADDR), .RAM_WDATA(RAM_WDATA), .RAM_BE(RAM_BE),
    .RAM_WE(RAM_WE), .RAM_RE(RAM_RE), .RAM_RDATA(RAM_RDATA)
  );

  // Synchronous RAM: 1024 words, indexed by the low word-address bits
  logic [31:0] ram [1024];
  logic        ram_cleared = 1'b0;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] d,
                                        input logic [3:0] be);
    logic [31:0] w;
    w = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = d[8*i +: 8];
    return w;
  endfunction

  always @(posedge CLK) begin
    if (!ram_cleared) begin
      for (int i = 0; i < 1024; i++) ram[i] <= 32'h0;
      RAM_RDATA   <= 32'h0;
      ram_cleared <= 1'b1;
    end else begin
      if (RAM_RE) RAM_RDATA <= ram[RAM_ADDR[9:0]];
      if (RAM_WE) ram[RAM_ADDR[9:0]] <= merge(ram[RAM_ADDR[9:0]], RAM_WDATA, RAM_BE);
    end
  end

  // Reference model: flat byte-addressed memory, little-endian
  logic [7:0] rmem [int unsigned];

  function automatic int nbytes_of(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [7:0] rbyte(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : 8'h00;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] s,
                                           input logic u);
    logic [31:0] v;
    int n;
    n = nbytes_of(s);
    v = 32'h0;
    for (int k = 0; k < n; k++) v = v | (32'(rbyte(a + 32'(k))) << (8 * k));
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    for (int k = 0; k < nbytes_of(s); k++) rmem[a + 32'(k)] = d[8*k +: 8];
  endtask

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] last_dout = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request, checked through its whole lifetime and the idle cycle after
  task automatic txn(input string tag, input logic rd, input logic we,
                     input logic [31:0] addr, input logic [31:0] din,
                     input logic [1:0] size, input logic uns,
                     input logic exp_err, input logic [31:0] exp_dout);
    int n, off, b;
    logic mis;
    logic [3:0] be1, be2;
    logic [29:0] wa, wa2;
    n = nbytes_of(size);
    off = int'(addr[1:0]);
    mis = !exp_err && (off + n > 4);
    be1 = 4'b0; be2 = 4'b0;
    for (int k = 0; k < n; k++) begin
      b = off + k;
      if (b < 4) be1[b] = 1'b1; else be2[b-4] = 1'b1;
    end
    wa = addr[31:2];
    wa2 = wa + 30'd1;
    @(negedge CLK);
    MEM_RDEN2 = rd; MEM_WE2 = we; MEM_ADDR2 = addr; MEM_DIN2 = din;
    MEM_SIZE = size; MEM_UNSIGNED = uns;
    #1;
    chk({tag, " re_n"}, 32'(RAM_RE), 32'(rd && !exp_err));
    chk({tag, " we_n"}, 32'(RAM_WE), 32'(we && !exp_err));
    if (!exp_err) chk({tag, " addr_n"}, 32'(RAM_ADDR), 32'(wa));
    if (we && !exp_err) chk({tag, " be_n"}, 32'(RAM_BE), 32'(be1));
    @(posedge CLK); #1;
    MEM_RDEN2 = 1'b0; MEM_WE2 = 1'b0;
    chk({tag, " err"}, 32'(ERR), 32'(exp_err));
    if (mis) begin
      chk({tag, " busy_b2"}, 32'(BUSY), 32'd1);
      chk({tag, " addr_b2"}, 32'(RAM_ADDR), 32'(wa2));
      if (rd) begin
        chk({tag, " re_b2"}, 32'(RAM_RE), 32'd1);
        @(posedge CLK); #1;
        chk({tag, " busy_ret"}, 32'(BUSY), 32'd1);
        chk({tag, " dout_split"}, MEM_DOUT2, exp_dout);
      end else begin
        chk({tag, " we_b2"}, 32'(RAM_WE), 32'd1);
        chk({tag, " be_b2"}, 32'(RAM_BE), 32'(be2));
      end
    end else if (rd && !exp_err) begin
      chk({tag, " dout"}, MEM_DOUT2, exp_dout);
    end
    @(posedge CLK); #1;
    chk({tag, " idle_busy"}, 32'(BUSY), 32'd0);
    chk({tag, " idle_strb"}, {29'd0, RAM_RE, RAM_WE, ERR}, 32'd0);
    chk({tag, " idle_be"}, 32'(RAM_BE), 32'd0);
    chk({tag, " hold"}, MEM_DOUT2, exp_dout);
    last_dout = exp_dout;
    $display("txn %s rd=%0d we=%0d addr=%h size=%0d err=%0d dout=%h",
             tag, rd, we, addr, size, exp_err, MEM_DOUT2);
  endtask

  typedef struct {
    logic        rd;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [1:0]  size;
    logic        uns;
    logic        err;
    logic [31:0] dout;
  } vec_t;

  vec_t vt [14];

  initial begin
    vt[0]  = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0, 1'b0, 32'h00000000};
    vt[1]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 1'b1, 32'h200, 32'h80FF7F01, 2'd2, 1'b0, 1'b0, 32'hDEADBEEF};
    vt[3]  = '{1'b1, 1'b0, 32'h202, 32'h0,        2'd0, 1'b0, 1'b0, 32'hFFFFFFFF};
    vt[4]  = '{1'b1, 1'b0, 32'h203, 32'h0,        2'd0, 1'b1, 1'b0, 32'h00000080};
    vt[5]  = '{1'b1, 1'b0, 32'h202, 32'h0,        2'd1, 1'b0, 1'b0, 32'hFFFF80FF};
    vt[6]  = '{1'b1, 1'b0, 32'h200, 32'h0,        2'd1, 1'b1, 1'b0, 32'h00007F01};
    vt[7]  = '{1'b1, 1'b0, 32'h201, 32'h0,        2'd0, 1'b0, 1'b0, 32'h0000007F};
    vt[8]  = '{1'b1, 1'b1, 32'h100, 32'h11111111, 2'd2, 1'b0, 1'b1, 32'h0000007F};
    vt[9]  = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd3, 1'b0, 1'b1, 32'h0000007F};
    vt[10] = '{1'b0, 1'b1, 32'h101, 32'h00000055, 2'd0, 1'b0, 1'b0, 32'h0000007F};
    vt[11] = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 1'b0, 32'hDEAD55EF};
    vt[12] = '{1'b0, 1'b1, 32'h102, 32'h00001234, 2'd1, 1'b0, 1'b0, 32'hDEAD55EF};
    vt[13] = '{1'b1, 1'b0, 32'h100, 32'h0,        2'd2, 1'b0, 1'b0, 32'h123455EF};

    // Reset: outputs forced low even with a request pending
    MEM_RDEN2 = 1'b1; MEM_SIZE = 2'd2; MEM_ADDR2 = 32'h100;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst dout", MEM_DOUT2, 32'h0);
    chk("rst busy_err", {30'd0, BUSY, ERR}, 32'd0);
    chk("rst strobes", {26'd0, RAM_BE, RAM_RE, RAM_WE}, 32'd0);
    MEM_RDEN2 = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;

    // Directed table
    for (int i = 0; i < 14; i++) begin
      txn($sformatf("vec%0d", i), vt[i].rd, vt[i].we, vt[i].addr, vt[i].din,
          vt[i].size, vt[i].uns, vt[i].err, vt[i].dout);
      if (vt[i].we && !vt[i].err) ref_store(vt[i].addr, vt[i].din, vt[i].size);
    end

    // Misaligned half store at offset 3
`ifdef MEM_SPLIT_MISALIGNED_EN
    @(negedge CLK);
    MEM_WE2 = 1'b1; MEM_ADDR2 = 32'h103; MEM_DIN2 = 32'h0000ABCD; MEM_SIZE = 2'd1;
    #1;
    chk("sth beat1 be", 32'(RAM_BE), 32'h8);
    chk("sth beat1 addr", 32'(RAM_ADDR), 32'h40);
    chk("sth beat1 byte3", 32'(RAM_WDATA[31:24]), 32'hCD);
    @(posedge CLK); #1;
    MEM_WE2 = 1'b0;
    chk("sth beat2 busy", 32'(BUSY), 32'd1);
    chk("sth beat2 be", 32'(RAM_BE), 32'h1);
    chk("sth beat2 addr", 32'(RAM_ADDR), 32'h41);
    chk("sth beat2 byte0", 32'(RAM_WDATA[7:0]), 32'hAB);
    @(posedge CLK); #1;
    chk("sth busy end", {30'd0, BUSY, RAM_WE}, 32'd0);
    ref_store(32'h103, 32'h0000ABCD, 2'd1);
    $display("txn sth_103 split store done");
`else
    txn("sth_103", 1'b0, 1'b1, 32'h103, 32'h0000ABCD, 2'd1, 1'b0, 1'b1, last_dout);
`endif

    // Misaligned word load spanning words 0x7F/0x80
    txn("st_1fc", 1'b0, 1'b1, 32'h1FC, 32'h44331122, 2'd2, 1'b0, 1'b0, last_dout);
    ref_store(32'h1FC, 32'h44331122, 2'd2);
    txn("st_200", 1'b0, 1'b1, 32'h200, 32'h99886655, 2'd2, 1'b0, 1'b0, last_dout);
    ref_store(32'h200, 32'h99886655, 2'd2);
`ifdef MEM_SPLIT_MISALIGNED_EN
    txn("ldw_1fe", 1'b1, 1'b0, 32'h1FE, 32'h0, 2'd2, 1'b0, 1'b0, 32'h66554433);
    // Word-address wrap on the second beat
    txn("stw_wrap", 1'b0, 1'b1, 32'hFFFFFFFE, 32'hA1B2C3D4, 2'd2, 1'b0, 1'b0, last_dout);
    ref_store(32'hFFFFFFFE, 32'hA1B2C3D4, 2'd2);
    txn("ldw_wrap", 1'b1, 1'b0, 32'hFFFFFFFE, 32'h0, 2'd2, 1'b0, 1'b0, 32'hA1B2C3D4);
    txn("ldh_wrap", 1'b1, 1'b0, 32'hFFFFFFFF, 32'h0, 2'd1, 1'b0, 1'b0, 32'hFFFFB2C3);
`else
    txn("ldw_1fe", 1'b1, 1'b0, 32'h1FE, 32'h0, 2'd2, 1'b0, 1'b1, last_dout);
    txn("stw_wrap", 1'b0, 1'b1, 32'hFFFFFFFE, 32'hA1B2C3D4, 2'd2, 1'b0, 1'b1, last_dout);
`endif

    // Randomized traffic against the byte-level model
    for (int i = 0; i < 150; i++) begin
      logic rd, we, uns, e, crosses;
      logic [31:0] a, d, x;
      logic [1:0] s;
      int op, sz;
      op = int'($urandom_range(0, 9));
      rd = (op <= 4) || (op == 9);
      we = (op >= 5);
      sz = int'($urandom_range(0, 7));
      s = (sz <= 1) ? 2'd0 : (sz <= 3) ? 2'd1 : (sz <= 6) ? 2'd2 : 2'd3;
      a = ($urandom_range(0, 1) == 0) ? 32'h100 + $urandom_range(0, 127)
                                      : 32'hFFFFFFC0 + $urandom_range(0, 63);
      d = $urandom;
      uns = $urandom_range(0, 1) == 1;
      crosses = (int'(a[1:0]) + nbytes_of(s)) > 4;
      e = (s == 2'd3) || (rd && we) || (crosses && !SPLIT_C);
      x = (rd && !e) ? ref_load(a, s, uns) : last_dout;
      txn($sformatf("rnd%0d", i), rd, we, a, d, s, uns, e, x);
      if (we && !e) ref_store(a, d, s);
    end

    // Reset in the middle of a load: everything drops at once, nothing resumes
    @(negedge CLK);
    MEM_RDEN2 = 1'b1; MEM_SIZE = 2'd2;
    MEM_ADDR2 = SPLIT_C ? 32'h1FE : 32'h100;
    @(posedge CLK); #1;
    MEM_RDEN2 = 1'b0;
    RST_N = 1'b0;
    #1;
    chk("abort busy", 32'(BUSY), 32'd0);
    chk("abort re", 32'(RAM_RE), 32'd0);
    chk("abort dout", MEM_DOUT2, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("post_abort%0d strobes", i), {29'd0, RAM_RE, RAM_WE, BUSY}, 32'd0);
      chk($sformatf("post_abort%0d dout", i), MEM_DOUT2, 32'h0);
    end
    $display("txn abort_on_reset done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
